// File: rtl/pulse_width_gen.sv
// pulse_width_gen: emits one pulse on `a` whose high time is the requested
// number of clk cycles, held inside [MIN_HIGH, MAX_HIGH], followed by at least
// MIN_LOW cycles of GAP before the next request can be accepted.
//
// Configuration macro: PULSE_WIDTH_GEN_CLAMP_EN
//   defined   - out-of-range lengths are clamped into the window and emitted
//   undefined - out-of-range requests are accepted and dropped (no pulse)
//   In both builds len_err strobes one cycle after an out-of-range acceptance.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  combinational: idle and not in reset
//   req_len    in   requested high duration, sampled only at acceptance
//   a          out  generated pulse (registered)
//   busy       out  state is not IDLE (registered)
//   done       out  strobe during the last high cycle of `a` (registered)
//   len_err    out  strobe the cycle after an out-of-range acceptance (registered)

module pulse_width_gen #(
  parameter int unsigned MIN_HIGH = 2,
  parameter int unsigned MAX_HIGH = 6,
  parameter int unsigned LEN_W    = 3,
  parameter int unsigned MIN_LOW  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_len,
  output logic             a,
  output logic             busy,
  output logic             done,
  output logic             len_err
);

  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_HIGH);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_HIGH);
  localparam logic [LEN_W-1:0] GAP_INIT = LEN_W'(MIN_LOW - 1);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             done_nxt;
  logic             len_err_nxt;

  logic             accept;
  logic             len_lo;
  logic             len_hi;
  logic             len_bad;
  logic [LEN_W-1:0] eff_len;

  // Handshake: only IDLE accepts, and never while reset is asserted.
  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Range classification of the incoming length.
  assign len_lo  = (req_len < MIN_LEN);
  assign len_hi  = (req_len > MAX_LEN);
  assign len_bad = len_lo || len_hi;

  // Length actually emitted; only meaningful when the pulse is issued.
  always_comb begin
    eff_len = req_len;
    if (len_lo) begin
      eff_len = MIN_LEN;
    end else if (len_hi) begin
      eff_len = MAX_LEN;
    end
  end

  // Next-state, counter and strobe logic.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    len_err_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          len_err_nxt = len_bad;
`ifdef PULSE_WIDTH_GEN_CLAMP_EN
          state_nxt = HIGH;
          cnt_nxt   = eff_len - ONE;
`else
          if (!len_bad) begin
            state_nxt = HIGH;
            cnt_nxt   = eff_len - ONE;
          end
`endif
        end
      end

      HIGH: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - ONE;
        end else begin
          state_nxt = GAP;
          cnt_nxt   = GAP_INIT;
        end
      end

      GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - ONE;
        end else begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // done is registered, so it is raised on entry to the final high cycle.
    done_nxt = (state_nxt == HIGH) && (cnt_nxt == '0);
  end

  // State and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      a       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      len_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      a       <= (state_nxt == HIGH);
      busy    <= (state_nxt != IDLE);
      done    <= done_nxt;
      len_err <= len_err_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_width_gen.sv
// Self-checking bench for pulse_width_gen: a timestamp-based model predicts
// every output each cycle, a run-length monitor measures pulse/gap widths,
// and directed plus random stimulus exercises the generator.

module tb_pulse_width_gen;

  localparam int unsigned MIN_HIGH = 2;
  localparam int unsigned MAX_HIGH = 6;
  localparam int unsigned LEN_W    = 3;
  localparam int unsigned MIN_LOW  = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [LEN_W-1:0] req_len = '0;
  logic             a;
  logic             busy;
  logic             done;
  logic             len_err;

  int checks = 0;
  int errors = 0;

  // Monitor results
  int last_high_len = 0;
  int last_low_len  = 0;
  int pulse_cnt     = 0;
  int done_cnt      = 0;
  int err_cnt       = 0;
  int acc_cnt       = 0;

  pulse_width_gen #(
    .MIN_HIGH (MIN_HIGH),
    .MAX_HIGH (MAX_HIGH),
    .LEN_W    (LEN_W),
    .MIN_LOW  (MIN_LOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_len   (req_len),
    .a         (a),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Pulse length the generator must emit for a request; 0 means dropped.
  function automatic int model_len(input int len);
`ifdef PULSE_WIDTH_GEN_CLAMP_EN
    if (len < int'(MIN_HIGH)) return int'(MIN_HIGH);
    if (len > int'(MAX_HIGH)) return int'(MAX_HIGH);
    return len;
`else
    if (len < int'(MIN_HIGH) || len > int'(MAX_HIGH)) return 0;
    return len;
`endif
  endfunction

  // Model: cycle c is the interval after the c-th rising edge. A pulse is
  // described by [hi_start, hi_end); requests are accepted only while
  // c >= free_at, and len_err is expected exactly in cycle err_cyc.
  initial begin : compare
    int c, t, n, run_len, hi_start, hi_end, err_cyc, free_at;
    logic a_prev, rst_s, exp_a, exp_done;
    c = 0; hi_start = 0; hi_end = 0; err_cyc = -1; free_at = 0;
    run_len = 0; a_prev = 1'b0;
    forever begin
      @(posedge clk);
      rst_s = rst;
      t = c + 1;
      if (rst) begin
        hi_start = 0; hi_end = 0; err_cyc = -1; free_at = t;
      end else if (req_valid && c >= free_at) begin
        acc_cnt++;
        n = model_len(int'(req_len));
        err_cyc = (int'(req_len) < int'(MIN_HIGH) || int'(req_len) > int'(MAX_HIGH)) ? t : -1;
        if (n > 0) begin
          hi_start = t;
          hi_end   = t + n;
          free_at  = t + n + int'(MIN_LOW);
        end
      end
      c = t;
      #1;
      exp_a    = (c >= hi_start) && (c < hi_end);
      exp_done = (hi_end > hi_start) && (c == hi_end - 1);
      chk("a",       32'(a),       32'(exp_a));
      chk("done",    32'(done),    32'(exp_done));
      chk("busy",    32'(busy),    32'(c < free_at));
      chk("len_err", 32'(len_err), 32'(c == err_cyc));

      // Run-length monitor and 2..6 high-window property.
      if (a !== a_prev) begin
        if (a_prev) begin
          last_high_len = run_len;
          pulse_cnt++;
          if (!rst_s)
            chk("high_window", 32'(run_len >= int'(MIN_HIGH) && run_len <= int'(MAX_HIGH)), 32'd1);
        end else begin
          last_low_len = run_len;
        end
        run_len = 1;
      end else begin
        run_len++;
      end
      a_prev = a;
      if (done === 1'b1) done_cnt++;
      if (len_err === 1'b1) err_cnt++;

      @(negedge clk);
      #1;
      chk("req_ready", 32'(req_ready), 32'(c >= free_at && !rst));
    end
  end

  // Wait (bounded) until the generator is idle.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && a === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  // Issue one request when ready (bounded wait); returns in the cycle after acceptance.
  task automatic issue(input int len);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ready_timeout", 32'(ok), 32'd1);
    req_valid = 1'b1;
    req_len   = LEN_W'(len);
    @(negedge clk);
    req_valid = 1'b0;
    req_len   = LEN_W'($urandom_range(0, 7));
  endtask

  initial begin : stim
    int d0, p0, e0, r;

    // Reset for three cycles, then release.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    chk("post_reset_a",     32'(a),         32'd0);
    chk("post_reset_busy",  32'(busy),      32'd0);
    @(negedge clk);

    // Minimum and maximum legal widths.
    d0 = done_cnt;
    issue(2);
    wait_idle();
    chk("len2_high", 32'(last_high_len), 32'd2);
    chk("len2_done", 32'(done_cnt - d0), 32'd1);
    d0 = done_cnt;
    issue(6);
    wait_idle();
    chk("len6_high", 32'(last_high_len), 32'd6);
    chk("len6_done", 32'(done_cnt - d0), 32'd1);

    // Back-to-back length-3 requests with valid held high.
    p0 = pulse_cnt;
    req_valid = 1'b1;
    req_len   = 3'd3;
    repeat (18) @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    chk("b2b_high",  32'(last_high_len), 32'd3);
    chk("b2b_low",   32'(last_low_len),  32'd2);
    chk("b2b_count", 32'(pulse_cnt - p0 >= 3), 32'd1);

    // Out-of-range lengths.
    p0 = pulse_cnt; e0 = err_cnt;
    issue(7);
    repeat (2) @(negedge clk);
    wait_idle();
    chk("len7_err", 32'(err_cnt - e0), 32'd1);
`ifdef PULSE_WIDTH_GEN_CLAMP_EN
    chk("len7_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("len7_high",   32'(last_high_len),  32'd6);
`else
    chk("len7_pulses", 32'(pulse_cnt - p0), 32'd0);
`endif
    p0 = pulse_cnt; e0 = err_cnt;
    issue(1);
    repeat (2) @(negedge clk);
    wait_idle();
    chk("len1_err", 32'(err_cnt - e0), 32'd1);
`ifdef PULSE_WIDTH_GEN_CLAMP_EN
    chk("len1_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("len1_high",   32'(last_high_len),  32'd2);
`else
    chk("len1_pulses", 32'(pulse_cnt - p0), 32'd0);
`endif

    // Reset during the third high cycle of a length-5 pulse.
    d0 = done_cnt;
    issue(5);
    repeat (2) @(negedge clk);
    chk("pre_reset_a", 32'(a), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_mid_a",    32'(a),    32'd0);
    chk("reset_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mid_done", 32'(done_cnt - d0), 32'd0);
    issue(4);
    wait_idle();
    chk("after_reset_high", 32'(last_high_len), 32'd4);

    // Random requests, mostly legal, with occasional resets.
    r = acc_cnt;
    for (int i = 0; i < 6000 && (acc_cnt - r) < 200; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0)
        req_len = LEN_W'($urandom_range(0, 7));
      else
        req_len = LEN_W'($urandom_range(MIN_HIGH, MAX_HIGH));
      @(negedge clk);
    end
    rst = 1'b0;
    req_valid = 1'b0;
    chk("random_accepts", 32'((acc_cnt - r) >= 200), 32'd1);
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
